// File: rtl/pong_pkg.sv
// Shared encodings and output-word layout for the pong_field block.
package pong_pkg;

  typedef enum logic [2:0] {
    SERVE_L  = 3'd0,
    SERVE_R  = 3'd1,
    PLAY     = 3'd2,
    POINT    = 3'd3,
    GAMEOVER = 3'd4
  } state_t;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_t;

  localparam int POINT_FLASH_TICKS = 4;
  localparam int STATE_W           = 3;

  // Output word is {state, score_r, score_l, leds}, LSB first.
  function automatic int leds_lsb();
    return 0;
  endfunction

  function automatic int score_l_lsb(int num_leds);
    return num_leds;
  endfunction

  function automatic int score_r_lsb(int num_leds, int score_w);
    return num_leds + score_w;
  endfunction

  function automatic int state_lsb(int num_leds, int score_w);
    return num_leds + 2 * score_w;
  endfunction

  function automatic int out_width(int num_leds, int score_w);
    return num_leds + 2 * score_w + STATE_W;
  endfunction

endpackage

// File: rtl/pong_field_ticker.sv
// Ball-step timer for pong_field. PONG_SPEEDUP_EN adds a per-rally shrinking step length.
module pong_ticker #(
  parameter int TICK_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              hit,
  input  logic              load,
  input  logic [TICK_W-1:0] tick_length,
  output logic              tick
);

  logic [TICK_W-1:0] live_len;
  logic [TICK_W-1:0] eff_len;
  logic [TICK_W-1:0] cnt;

  assign live_len = (tick_length == '0) ? TICK_W'(1) : tick_length;

`ifdef PONG_SPEEDUP_EN
  logic [TICK_W-1:0] fast_len;
  logic [TICK_W-1:0] shrunk;

  assign shrunk = fast_len - (fast_len >> 3);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      fast_len <= live_len;
    end else if (hit) begin
      fast_len <= (shrunk == '0) ? TICK_W'(1) : shrunk;
    end
  end

  assign eff_len = fast_len;
`else
  logic unused_load;
  assign unused_load = load;
  assign eff_len     = live_len;
`endif

  // Shrinking tick_length below the running count fires at once rather than wrapping.
  assign tick = run && (cnt >= eff_len - TICK_W'(1));

  // NOTE: non-blocking assignments make every register sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || !run || hit || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TICK_W'(1);
    end
  end

endmodule

// File: rtl/pong_field.sv
// Two-player 1D pong on an N-LED strip; optional macro PONG_SPEEDUP_EN speeds the ball on hits.
module pong_field
  import pong_pkg::*;
#(
  parameter int NUM_LEDS   = 8,
  parameter int TICK_W     = 32,
  parameter int SCORE_W    = 4,
  parameter int WIN_SCORE  = 9,
  parameter int HIT_WINDOW = 1
) (
  input  logic                                      _i_clk,
  input  logic                                      _i_rst,
  input  logic [TICK_W-1:0]                         _i_tick_length,
  input  logic                                      _i_btn_left,
  input  logic                                      _i_btn_right,
  output logic [out_width(NUM_LEDS, SCORE_W)-1:0]   __output
);

  localparam int POS_W   = $clog2(NUM_LEDS);
  localparam int FLASH_W = $clog2(POINT_FLASH_TICKS);

  localparam logic [POS_W-1:0]    LAST_POS   = POS_W'(NUM_LEDS - 1);
  localparam logic [POS_W-1:0]    R_WIN_LO   = POS_W'(NUM_LEDS - HIT_WINDOW);
  localparam logic [POS_W-1:0]    L_WIN_HI   = POS_W'(HIT_WINDOW - 1);
  localparam logic [SCORE_W-1:0]  WIN        = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0]  SCORE_MAX  = '1;
  localparam logic [FLASH_W-1:0]  FLASH_LAST = FLASH_W'(POINT_FLASH_TICKS - 1);
  localparam logic [NUM_LEDS-1:0] ALL_ON     = '1;
  localparam logic [NUM_LEDS-1:0] HALF_LO    = ALL_ON >> (NUM_LEDS - NUM_LEDS / 2);
  localparam logic [NUM_LEDS-1:0] HALF_HI    = ~(ALL_ON >> (NUM_LEDS / 2));

  function automatic logic [NUM_LEDS-1:0] onehot(logic [POS_W-1:0] p);
    return {{(NUM_LEDS-1){1'b0}}, 1'b1} << p;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_inc(logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + 1'b1;
  endfunction

  state_t              state;
  dir_t                dir;
  logic [POS_W-1:0]    pos;
  logic [SCORE_W-1:0]  score_l;
  logic [SCORE_W-1:0]  score_r;
  logic                scorer_right;
  logic [FLASH_W-1:0]  flash_cnt;
  logic [NUM_LEDS-1:0] leds;
  logic                prev_l;
  logic                prev_r;

  logic             press_l, press_r, hit_l, hit_r, hit, serve_start, run, tick, at_end;
  logic [POS_W-1:0] pos_next;

  assign press_l     = _i_btn_left  & ~prev_l;
  assign press_r     = _i_btn_right & ~prev_r;
  assign hit_r       = (state == PLAY) && press_r && (dir == DIR_RIGHT) && (pos >= R_WIN_LO);
  assign hit_l       = (state == PLAY) && press_l && (dir == DIR_LEFT)  && (pos <= L_WIN_HI);
  assign hit         = hit_l | hit_r;
  assign serve_start = ((state == SERVE_L) && press_l) || ((state == SERVE_R) && press_r);
  assign run         = (state == PLAY) || (state == POINT);
  assign at_end      = (dir == DIR_RIGHT) ? (pos == LAST_POS) : (pos == '0);
  assign pos_next    = (dir == DIR_RIGHT) ? pos + 1'b1 : pos - 1'b1;

  pong_ticker #(.TICK_W(TICK_W)) u_ticker (
    .clk         (_i_clk),
    .rst         (_i_rst),
    .run         (run),
    .hit         (hit),
    .load        (serve_start),
    .tick_length (_i_tick_length),
    .tick        (tick)
  );

  always_ff @(posedge _i_clk) begin
    if (_i_rst) begin
      state        <= SERVE_L;
      dir          <= DIR_RIGHT;
      pos          <= '0;
      score_l      <= '0;
      score_r      <= '0;
      scorer_right <= 1'b0;
      flash_cnt    <= '0;
      leds         <= onehot('0);
      prev_l       <= 1'b0;
      prev_r       <= 1'b0;
    end else begin
      prev_l <= _i_btn_left;
      prev_r <= _i_btn_right;
      unique case (state)
        SERVE_L: if (press_l) begin
          state <= PLAY;
          dir   <= DIR_RIGHT;
        end
        SERVE_R: if (press_r) begin
          state <= PLAY;
          dir   <= DIR_LEFT;
        end
        PLAY: begin
          // A return press outranks a miss tick landing in the same cycle.
          if (hit_r) begin
            dir <= DIR_LEFT;
          end else if (hit_l) begin
            dir <= DIR_RIGHT;
          end else if (tick && at_end) begin
            state        <= POINT;
            flash_cnt    <= '0;
            leds         <= ALL_ON;
            scorer_right <= (dir == DIR_LEFT);
            if (dir == DIR_RIGHT) score_l <= sat_inc(score_l);
            else                  score_r <= sat_inc(score_r);
          end else if (tick) begin
            pos  <= pos_next;
            leds <= onehot(pos_next);
          end
        end
        POINT: if (tick) begin
          flash_cnt <= flash_cnt + 1'b1;
          if (flash_cnt == FLASH_LAST) begin
            if ((scorer_right ? score_r : score_l) == WIN) begin
              state <= GAMEOVER;
              leds  <= scorer_right ? HALF_HI : HALF_LO;
            end else if (scorer_right) begin
              state <= SERVE_L;
              pos   <= '0;
              leds  <= onehot('0);
            end else begin
              state <= SERVE_R;
              pos   <= LAST_POS;
              leds  <= onehot(LAST_POS);
            end
          end
        end
        GAMEOVER: ;
        default: state <= SERVE_L;
      endcase
    end
  end

  assign __output[leds_lsb() +: NUM_LEDS]                = leds;
  assign __output[score_l_lsb(NUM_LEDS) +: SCORE_W]       = score_l;
  assign __output[score_r_lsb(NUM_LEDS, SCORE_W) +: SCORE_W] = score_r;
  assign __output[state_lsb(NUM_LEDS, SCORE_W) +: STATE_W]   = state;

endmodule

// File: tb/tb_pong_field.sv
// Self-checking bench for pong_field: per-cycle behavioural model plus directed literal checks.
`timescale 1ns/1ps
module tb_pong_field;
  import pong_pkg::*;

  localparam int N  = 8;
  localparam int TW = 32;
  localparam int SW = 4;
  localparam int WS = 9;
  localparam int HW = 1;
  localparam int OW = out_width(N, SW);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bl  = 1'b0;
  logic          br  = 1'b0;
  logic [TW-1:0] tlen = 32'd3;
  logic [OW-1:0] out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pong_field #(
    .NUM_LEDS(N), .TICK_W(TW), .SCORE_W(SW), .WIN_SCORE(WS), .HIT_WINDOW(HW)
  ) dut (
    ._i_clk         (clk),
    ._i_rst         (rst),
    ._i_tick_length (tlen),
    ._i_btn_left    (bl),
    ._i_btn_right   (br),
    .__output       (out)
  );

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] pack(int st, int sl, int sr, int leds);
    logic [OW-1:0] w;
    w = '0;
    w[leds_lsb() +: N]            = N'(leds);
    w[score_l_lsb(N) +: SW]       = SW'(sl);
    w[score_r_lsb(N, SW) +: SW]   = SW'(sr);
    w[state_lsb(N, SW) +: 3]      = 3'(st);
    return w;
  endfunction

  function automatic int f_leds();
    return int'(out[leds_lsb() +: N]);
  endfunction

  function automatic int f_state();
    return int'(out[state_lsb(N, SW) +: 3]);
  endfunction

  // ---------------- behavioural model ----------------
  int m_state, m_pos, m_dir, m_sl, m_sr, m_age, m_flash, m_eff;
  bit m_prev_l, m_prev_r, m_right_scored, m_valid = 1'b0;

  function automatic int live();
    return (tlen == 0) ? 1 : int'(tlen);
  endfunction

  function automatic logic [OW-1:0] model_word();
    int leds;
    if (m_state == 3)      leds = (1 << N) - 1;
    else if (m_state == 4) leds = m_right_scored ? (((1 << (N/2)) - 1) << (N - N/2)) : ((1 << (N/2)) - 1);
    else                   leds = 1 << m_pos;
    return pack(m_state, m_sl, m_sr, leds);
  endfunction

  task automatic model_step();
    bit pl, pr, hit;
    int eff;
    pl = bl && !m_prev_l;
    pr = br && !m_prev_r;
    m_prev_l = bl;
    m_prev_r = br;
    if (rst) begin
      m_state = 0; m_pos = 0; m_dir = 1; m_sl = 0; m_sr = 0; m_age = 0; m_flash = 0;
      m_prev_l = 0; m_prev_r = 0; m_eff = live(); m_right_scored = 0; m_valid = 1;
      return;
    end
    if (!m_valid) return;
`ifdef PONG_SPEEDUP_EN
    eff = m_eff;
`else
    eff = live();
`endif
    case (m_state)
      0: if (pl) begin m_state = 2; m_dir = 1;  m_age = 0; m_eff = live(); end
      1: if (pr) begin m_state = 2; m_dir = -1; m_age = 0; m_eff = live(); end
      2: begin
        hit = (pr && m_dir == 1 && m_pos >= N - HW) || (pl && m_dir == -1 && m_pos < HW);
        if (hit) begin
          m_dir = -m_dir;
          m_age = 0;
          m_eff = m_eff - m_eff / 8;
          if (m_eff < 1) m_eff = 1;
        end else begin
          m_age++;
          if (m_age >= eff) begin
            m_age = 0;
            if (m_pos + m_dir < 0 || m_pos + m_dir >= N) begin
              m_right_scored = (m_dir == -1);
              if (m_right_scored) m_sr = (m_sr == 15) ? 15 : m_sr + 1;
              else                m_sl = (m_sl == 15) ? 15 : m_sl + 1;
              m_state = 3;
              m_flash = 0;
            end else begin
              m_pos += m_dir;
            end
          end
        end
      end
      3: begin
        m_age++;
        if (m_age >= eff) begin
          m_age = 0;
          m_flash++;
          if (m_flash == 4) begin
            if ((m_right_scored ? m_sr : m_sl) == WS) m_state = 4;
            else if (m_right_scored) begin m_state = 0; m_pos = 0; end
            else begin m_state = 1; m_pos = N - 1; end
          end
        end
      end
      default: ;
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) check("cycle", 32'(out), 32'(model_word()));
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_out(string name, int st, int sl, int sr, int leds);
    check(name, 32'(out), 32'(pack(st, sl, sr, leds)));
  endtask

  task automatic tap_l();
    bl = 1'b1; cyc(1); bl = 1'b0;
  endtask

  task automatic tap_r();
    br = 1'b1; cyc(1); br = 1'b0;
  endtask

  task automatic wait_state(int st, int budget);
    int n = 0;
    while (f_state() != st && n < budget) begin cyc(1); n++; end
    check("wait_state", f_state(), st);
  endtask

  task automatic wait_leds(int v, int budget);
    int n = 0;
    while (f_leds() != v && n < budget) begin cyc(1); n++; end
    check("wait_leds", f_leds(), v);
  endtask

  task automatic gap(string name, int exp);
    int n = 0;
    int l0;
    l0 = f_leds();
    while (f_leds() == l0 && n < 100) begin cyc(1); n++; end
    check(name, n, exp);
  endtask

  initial begin
    // Reset
    cyc(5);
    expect_out("reset", 0, 0, 0, 'h01);
    rst = 1'b0;

    // Left serve, steps every 3 cycles
    tap_l();
    expect_out("serve_l_play", 2, 0, 0, 'h01);
    for (int k = 1; k < N; k++) begin
      cyc(2); check("step_hold", f_leds(), 1 << (k - 1));
      cyc(1); check("step", f_leds(), 1 << k);
    end

    // Right misses
    cyc(3);  expect_out("miss_right", 3, 1, 0, 'hFF);
    cyc(11); expect_out("flash_last", 3, 1, 0, 'hFF);
    cyc(1);  expect_out("serve_r", 1, 1, 0, 'h80);

    // Right serve, left returns and keeps holding
    tap_r();
    expect_out("serve_r_play", 2, 1, 0, 'h80);
    cyc(21); check("reach_left", f_leds(), 'h01);
    bl = 1'b1;
    cyc(1); expect_out("hit_left", 2, 1, 0, 'h01);
    cyc(2); check("after_hit_hold", f_leds(), 'h01);
    cyc(1); check("after_hit_step", f_leds(), 'h02);
    cyc(18); check("reach_right", f_leds(), 'h80);
    br = 1'b1; cyc(1); br = 1'b0;
    cyc(21); check("back_left", f_leds(), 'h01);
    cyc(3);  expect_out("held_no_retrigger", 3, 1, 1, 'hFF);
    bl = 1'b0;
    cyc(12); expect_out("serve_l_after_r", 0, 1, 1, 'h01);

    // Press outside the window is ignored
    tap_l();
    cyc(15); check("at_pos5", f_leds(), 'h20);
    br = 1'b1; cyc(1); br = 1'b0;
    expect_out("outside_window", 2, 1, 1, 'h20);
    cyc(8);  expect_out("miss_after_ignored", 3, 2, 1, 'hFF);
    cyc(12); expect_out("serve_r2", 1, 2, 1, 'h80);

    // Hit press coincident with the miss tick
    tap_r();
    cyc(23);
    bl = 1'b1; cyc(1); bl = 1'b0;
    expect_out("hit_beats_miss", 2, 2, 1, 'h01);
    cyc(3); check("hit_beats_miss_step", f_leds(), 'h02);
    wait_state(3, 100);
    expect_out("miss3", 3, 3, 1, 'hFF);
    wait_state(1, 100);
    expect_out("serve_r3", 1, 3, 1, 'h80);

    // tick_length = 0 behaves as 1
    tlen = 32'd0;
    tap_r();
    cyc(1); check("fast_step1", f_leds(), 'h40);
    cyc(1); check("fast_step2", f_leds(), 'h20);
    cyc(6); expect_out("fast_miss", 3, 3, 2, 'hFF);
    cyc(3); expect_out("fast_flash", 3, 3, 2, 'hFF);
    cyc(1); expect_out("fast_serve_l", 0, 3, 2, 'h01);
    tlen = 32'd3;

    // Left wins to 9
    tap_l();
    wait_state(3, 100);
    wait_state(1, 100);
    for (int i = 0; i < 5; i++) begin
      tap_r();
      wait_leds('h01, 100);
      tap_l();
      wait_state(3, 200);
      if (i < 4) wait_state(1, 100);
      else       wait_state(4, 100);
    end
    expect_out("gameover", 4, 9, 2, 'h0F);
    for (int i = 0; i < 100; i++) begin
      bl = 1'($urandom_range(0, 1));
      br = 1'($urandom_range(0, 1));
      cyc(1);
    end
    bl = 1'b0; br = 1'b0;
    expect_out("gameover_hold", 4, 9, 2, 'h0F);

    // Reset from game over and mid-play
    rst = 1'b1; cyc(1); rst = 1'b0;
    expect_out("reset_gameover", 0, 0, 0, 'h01);
    tap_l();
    cyc(4); check("pre_reset_step", f_leds(), 'h02);
    rst = 1'b1; cyc(1);
    expect_out("reset_mid_play", 0, 0, 0, 'h01);
    rst = 1'b0;

    // Step spacing across hits
    tlen = 32'd16;
    cyc(1);
    tap_l();
    gap("gap_serve", 16);
    wait_leds('h80, 200);
    tap_r();
`ifdef PONG_SPEEDUP_EN
    gap("gap_hit1", 14);
    wait_leds('h01, 200);
    tap_l();
    gap("gap_hit2", 13);
    wait_leds('h80, 200);
    tap_r();
    gap("gap_hit3", 12);
`else
    gap("gap_hit1", 16);
    wait_leds('h01, 200);
    tap_l();
    gap("gap_hit2", 16);
    wait_leds('h80, 200);
    tap_r();
    gap("gap_hit3", 16);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pong_field.md
Name: pong_field

Overview:
- Parametrised successor to the single-player 1D pong block.
- Two players, each with a paddle button, play on an N-LED strip.
- Ball movement is timed by a runtime tick length. The block scores misses, runs serve/point/game-over sequencing, and packs LEDs, scores and state into one output word for the top-level display driver.

Parameters:
NUM_LEDS, 8, LED strip length (>=4)
TICK_W, 32, width of tick-length input and tick counter
SCORE_W, 4, width of each score counter
WIN_SCORE, 9, score that ends the game (< 2^SCORE_W)
HIT_WINDOW, 1, number of end LEDs on each side where a paddle press returns the ball (1..NUM_LEDS/2)

Ports:
_i_clk  input  1  clock; single clock domain
_i_rst  input  1  synchronous active-high reset
_i_tick_length  input  TICK_W  cycles per ball step; 0 is treated as 1
_i_btn_left  input  1  left paddle button, synchronous level
_i_btn_right  input  1  right paddle button, synchronous level
__output  output  NUM_LEDS+2*SCORE_W+3  {state[2:0], score_r, score_l, leds[NUM_LEDS-1:0]}, all registered

Behaviour:
- Reset (synchronous, active-high, overrides everything including mid-game):
  - state=SERVE_L, pos=0, dir=right.
  - Scores 0, tick counter 0, button history 0.
  - leds=one-hot bit 0.
- Buttons: press = rising edge (level high, previous-cycle level low). A held button never repeats.
- Tick:
  - eff_len = max(_i_tick_length, 1).
  - Counter increments every cycle in PLAY and POINT; tick fires when cnt==eff_len-1, then cnt<=0.
  - Counter is held at 0 in SERVE_L, SERVE_R and GAMEOVER.
  - _i_tick_length is sampled live.
- States: SERVE_L=0, SERVE_R=1, PLAY=2, POINT=3, GAMEOVER=4.
- SERVE_L:
  - Ball held at pos 0.
  - Left press -> PLAY, dir=right, cnt=0.
  - Right press is ignored.
- SERVE_R: mirror of SERVE_L; pos NUM_LEDS-1, right press, dir=left.
- PLAY, step: on tick the ball advances one LED in dir. The first step occurs eff_len cycles after entering PLAY.
- PLAY, hit:
  - A right press while dir=right and pos>=NUM_LEDS-HIT_WINDOW sets dir=left and cnt=0. Position is unchanged that cycle.
  - Left press is the mirror case.
  - Presses outside the window, or by the player the ball is moving away from, are ignored (no penalty).
- PLAY, miss:
  - Tick while pos==NUM_LEDS-1 and dir=right -> score_l+1, enter POINT, scorer=left.
  - Mirror for the left end.
- Simultaneous hit press and miss tick in the same cycle: the hit wins.
- POINT:
  - leds=all ones for exactly 4 ticks.
  - If the scorer's new score == WIN_SCORE -> GAMEOVER.
  - Otherwise the point loser serves: left scored -> SERVE_R, right scored -> SERVE_L, with pos set accordingly and cnt=0.
- GAMEOVER:
  - leds show the winner's half lit: upper NUM_LEDS/2 bits for right, lower bits for left.
  - Buttons are ignored; the state persists until reset.
- Scores saturate at 2^SCORE_W-1. This is unreachable when WIN_SCORE is legal.
- leds field in SERVE and PLAY states: one-hot of pos.
- All outputs update on the clock edge following the causing event; there are no combinational paths from inputs to __output.

Optional Feature:
- Macro: PONG_SPEEDUP_EN.
- Defined:
  - Each successful hit sets eff_len <= eff_len - (eff_len>>3), floor 1.
  - eff_len reloads from _i_tick_length on every SERVE->PLAY transition and on reset.
  - Adds one TICK_W register.
- Undefined: eff_len is always max(_i_tick_length, 1), and no extra register is present.

Decomposition:
- Package pong_pkg:
  - State encodings (3-bit).
  - Output field offset/width functions of NUM_LEDS and SCORE_W.
  - POINT_FLASH_TICKS=4.
- One sub-module, pong_ticker: tick counter with hold/clear inputs, eff_len input and tick pulse output. It contains the speedup register under PONG_SPEEDUP_EN.

Test Plan:
1. Defaults, tick_length=3: hold rst 5 cycles, release -> state=0, scores 0, leds=8'h01. Pulse rst mid-PLAY -> the same values on the next edge.
2. Left press -> state=2. leds steps 01,02,04,… with each step exactly 3 cycles apart, first step 3 cycles after entering PLAY.
3. No right press -> tick at leds=80 gives score_l=1, state=3, leds=FF for 12 cycles, then state=1 with leds=80.
4. SERVE_R, right press, ball reaches leds=01, left press -> dir reverses, next leds=02 3 cycles later. A held left button does not re-trigger.
5. Right press at leds=20 (pos 5, HIT_WINDOW=1) -> ignored, ball misses. Hit press in the same cycle as the miss tick -> returned, no score. tick_length=0 -> one step per cycle.
6. Drive left to 9 points -> state=4, leds=0F, score_l=9. Buttons are ignored for 100 cycles. With PONG_SPEEDUP_EN and tick_length=16, step spacing after hits is 16, 14, 13, 12.
